// File: rtl/ppu_pkg.sv
// Shared constants for the PPU background path: loopy v/t field offsets,
// CPU register indices and the 8-cycle tile fetch phase encoding.
package ppu_pkg;

  localparam int unsigned COARSE_X = 0;
  localparam int unsigned COARSE_Y = 5;
  localparam int unsigned NT_SEL   = 10;
  localparam int unsigned FINE_Y   = 12;

  localparam logic [2:0] PPUCTRL   = 3'd0;
  localparam logic [2:0] PPUSTATUS = 3'd2;
  localparam logic [2:0] PPUSCROLL = 3'd5;
  localparam logic [2:0] PPUADDR   = 3'd6;

  typedef enum logic [2:0] {
    PH_HI_CAP     = 3'd0,
    PH_NT_ADDR    = 3'd1,
    PH_NT_CAP     = 3'd2,
    PH_AT_ADDR    = 3'd3,
    PH_AT_CAP     = 3'd4,
    PH_PT_LO_ADDR = 3'd5,
    PH_PT_LO_CAP  = 3'd6,
    PH_PT_HI_ADDR = 3'd7
  } fetch_phase_e;

endpackage

// File: rtl/ppu_scroll_regs.sv
// Loopy scroll state: v, t, fine-x, write toggle and background table select,
// with the render-time increments/copies and the CPU register write path.
module ppu_scroll_regs
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [2:0]  cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        inc_x,
  input  logic        inc_y,
  input  logic        copy_x,
  input  logic        copy_y,
  output logic [14:0] v,
  output logic [2:0]  fine_x,
  output logic        bg_table
);

  logic [14:0] v_q, v_d, t_q, t_d;
  logic [2:0]  fx_q, fx_d;
  logic        w_q, w_d, bg_q, bg_d;

  always_comb begin
    v_d  = v_q;
    t_d  = t_q;
    fx_d = fx_q;
    w_d  = w_q;
    bg_d = bg_q;

    if (inc_x) begin
      if (v_d[COARSE_X +: 5] == 5'd31) begin
        v_d[COARSE_X +: 5] = '0;
        v_d[NT_SEL]        = ~v_d[NT_SEL];
      end else begin
        v_d[COARSE_X +: 5] = v_d[COARSE_X +: 5] + 5'd1;
      end
    end

    // Y step sees the already X-stepped value; the fields are disjoint.
    if (inc_y) begin
      if (v_d[FINE_Y +: 3] != 3'd7) begin
        v_d[FINE_Y +: 3] = v_d[FINE_Y +: 3] + 3'd1;
      end else begin
        v_d[FINE_Y +: 3] = '0;
        case (v_d[COARSE_Y +: 5])
          5'd29: begin
            v_d[COARSE_Y +: 5] = '0;
            v_d[NT_SEL + 1]    = ~v_d[NT_SEL + 1];
          end
          5'd31:   v_d[COARSE_Y +: 5] = '0;
          default: v_d[COARSE_Y +: 5] = v_d[COARSE_Y +: 5] + 5'd1;
        endcase
      end
    end

    if (copy_x) begin
      v_d[NT_SEL]        = t_q[NT_SEL];
      v_d[COARSE_X +: 5] = t_q[COARSE_X +: 5];
    end
    if (copy_y) begin
      v_d[14:11] = t_q[14:11];
      v_d[9:5]   = t_q[9:5];
    end

    // CPU path is evaluated last so a $2006 second write overrides render updates.
    if (cpu_wr) begin
      case (cpu_addr)
        PPUCTRL: begin
          t_d[11:10] = cpu_wdata[1:0];
          bg_d       = cpu_wdata[4];
        end
        PPUSCROLL: begin
          if (!w_q) begin
            t_d[4:0] = cpu_wdata[7:3];
            fx_d     = cpu_wdata[2:0];
            w_d      = 1'b1;
          end else begin
            t_d[14:12] = cpu_wdata[2:0];
            t_d[9:5]   = cpu_wdata[7:3];
            w_d        = 1'b0;
          end
        end
        PPUADDR: begin
          if (!w_q) begin
            t_d[13:8] = cpu_wdata[5:0];
            t_d[14]   = 1'b0;
            w_d       = 1'b1;
          end else begin
            t_d[7:0] = cpu_wdata;
            v_d      = t_d;
            w_d      = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (cpu_rd && cpu_addr == PPUSTATUS) w_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q  <= '0;
      t_q  <= '0;
      fx_q <= '0;
      w_q  <= 1'b0;
      bg_q <= 1'b0;
    end else begin
      v_q  <= v_d;
      t_q  <= t_d;
      fx_q <= fx_d;
      w_q  <= w_d;
      bg_q <= bg_d;
    end
  end

  assign v        = v_q;
  assign fine_x   = fx_q;
  assign bg_table = bg_q;

endmodule

// File: rtl/ppu_bg_fetch.sv
// Background tile fetch: turns cycle/scanline into VRAM reads, captures the
// nametable/attribute/pattern bytes and hands one tile per 8 cycles downstream.
module ppu_bg_fetch
  import ppu_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 14,
  parameter logic [ADDR_W-1:0]  NT_BASE   = 14'h2000,
  parameter logic [ADDR_W-1:0]  AT_OFFSET = 14'h03C0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rendering,
  input  logic [8:0]        cycle,
  input  logic [8:0]        scanline,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [2:0]        cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic [7:0]        vram_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd,
  output logic [7:0]        pattern_lo,
  output logic [7:0]        pattern_hi,
  output logic [1:0]        pal_sel,
  output logic              tile_valid,
  output logic [2:0]        fine_x,
  output logic [14:0]       v_addr
);

  fetch_phase_e      phase;
  logic              in_frame, in_win, dummy_nt, bg_table;
  logic [ADDR_W-1:0] nt_addr, at_addr, pt_lo_addr, pt_hi_addr, addr_hold_q;
  logic [7:0]        nt_q, at_q, lo_q, pat_lo_q, pat_hi_q, at_shifted;
  logic [2:0]        at_shift_q;
  logic [1:0]        pal_q;
  logic              tile_valid_q;

  assign phase    = fetch_phase_e'(cycle[2:0]);
  assign in_frame = rendering && (scanline < 9'd240 || scanline == 9'd261);
  assign in_win   = in_frame && ((cycle >= 9'd1 && cycle <= 9'd256) ||
                                 (cycle >= 9'd321 && cycle <= 9'd336));
  assign dummy_nt = in_frame && (cycle == 9'd337 || cycle == 9'd339);

  ppu_scroll_regs u_scroll (
    .clk       (clk),
    .reset     (reset),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .inc_x     (in_win && phase == PH_HI_CAP),
    .inc_y     (in_frame && cycle == 9'd256),
    .copy_x    (in_frame && cycle == 9'd257),
    .copy_y    (in_frame && scanline == 9'd261 && cycle >= 9'd280 && cycle <= 9'd304),
    .v         (v_addr),
    .fine_x    (fine_x),
    .bg_table  (bg_table)
  );

  assign nt_addr    = NT_BASE | ADDR_W'(v_addr[11:0]);
  assign at_addr    = NT_BASE | AT_OFFSET |
                      ADDR_W'({v_addr[11:10], 4'b0000, v_addr[9:7], v_addr[4:2]});
  assign pt_lo_addr = ADDR_W'({bg_table, nt_q, 1'b0, v_addr[14:12]});
  assign pt_hi_addr = pt_lo_addr + ADDR_W'(8);

  // Address is combinational so read data lands in the following phase;
  // outside a request it holds the last driven value.
  always_comb begin
    vram_rd   = 1'b0;
    vram_addr = addr_hold_q;
    if (!reset && in_win) begin
      case (phase)
        PH_NT_ADDR:    begin vram_rd = 1'b1; vram_addr = nt_addr;    end
        PH_AT_ADDR:    begin vram_rd = 1'b1; vram_addr = at_addr;    end
        PH_PT_LO_ADDR: begin vram_rd = 1'b1; vram_addr = pt_lo_addr; end
        PH_PT_HI_ADDR: begin vram_rd = 1'b1; vram_addr = pt_hi_addr; end
        default: ;
      endcase
    end else if (!reset && dummy_nt) begin
      vram_rd   = 1'b1;
      vram_addr = nt_addr;
    end
  end

  assign at_shifted = at_q >> at_shift_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_hold_q  <= '0;
      nt_q         <= '0;
      at_q         <= '0;
      lo_q         <= '0;
      at_shift_q   <= '0;
      pat_lo_q     <= '0;
      pat_hi_q     <= '0;
      pal_q        <= '0;
      tile_valid_q <= 1'b0;
    end else begin
      addr_hold_q  <= vram_addr;
      tile_valid_q <= 1'b0;
      if (in_win) begin
        case (phase)
          PH_NT_CAP:    nt_q       <= vram_rdata;
          PH_AT_ADDR:   at_shift_q <= {v_addr[6], v_addr[1], 1'b0};
          PH_AT_CAP:    at_q       <= vram_rdata;
          PH_PT_LO_CAP: lo_q       <= vram_rdata;
          PH_HI_CAP: begin
            pat_lo_q     <= lo_q;
            pat_hi_q     <= vram_rdata;
            pal_q        <= at_shifted[1:0];
            tile_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign pattern_lo = pat_lo_q;
  assign pattern_hi = pat_hi_q;
  assign pal_sel    = pal_q;
  assign tile_valid = tile_valid_q;

endmodule
